// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 4-bit ALU between two requesters.
// Grants one request at a time, runs it through the ALU for one cycle, then holds the result until consumed.
//
//  state | meaning
//  IDLE  | no operation in flight; the winning requester sees ready
//  EXEC  | latched operands drive the ALU; result captured on the edge
//  RESP  | result offered on the response port until rsp_ready
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       rr;
    logic       any_valid;
    logic       win;
    logic       accept;

    // win names the granted requester; rr only matters under contention
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        win        = (req0_valid & req1_valid) ? rr : req1_valid;
        req0_ready = (state == IDLE) && any_valid && !win;
        req1_ready = (state == IDLE) && any_valid && win;
        accept     = req0_ready | req1_ready;
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            alu_op   <= 2'd0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            rsp_data <= 4'd0;
            rsp_id   <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op <= win ? req1_op : req0_op;
                        alu_a  <= win ? req1_a  : req0_a;
                        alu_b  <= win ? req1_b  : req0_b;
                        rsp_id <= win;
                        rr     <= ~win;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU beside it.
// Uses CNT_W=2 so the completed-operation counter wraps within a short run.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op, alu_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] alu_a, alu_b, alu_out, rsp_data;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [1:0] op_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    alu_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation with rsp_ready held high, issued by a lone requester
    task automatic do_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp_data,
                         input logic [1:0] exp_cnt);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk("grant0", {7'd0, req0_ready}, {7'd0, ~id});
        chk("grant1", {7'd0, req1_ready}, {7'd0, id});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("exec_busy", {7'd0, busy}, 8'd1);
        chk("exec_valid", {7'd0, rsp_valid}, 8'd0);
        chk("exec_alu_a", {4'd0, alu_a}, {4'd0, a});
        chk("exec_alu_b", {4'd0, alu_b}, {4'd0, b});
        step();
        chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("rsp_data", {4'd0, rsp_data}, {4'd0, exp_data});
        chk("rsp_id", {7'd0, rsp_id}, {7'd0, id});
        step();
        chk("op_count", {6'd0, op_count}, {6'd0, exp_cnt});
        chk("idle_busy", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_count", {6'd0, op_count}, 8'd0);
        chk("rst_data", {4'd0, rsp_data}, 8'd0);
        chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // single add, then wrap arithmetic (counter 1,2,3)
        do_op(1'b0, 2'd0, 4'd5, 4'd3, 4'd8, 2'd1);
        do_op(1'b0, 2'd0, 4'd15, 4'd1, 4'd0, 2'd2);
        do_op(1'b1, 2'd1, 4'd3, 4'd5, 4'd14, 2'd3);

        // back-pressure: req1 OR held 5 cycles while req0 waits
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'd3; req1_a = 4'd5; req1_b = 4'd3;
        #1;
        chk("bp_grant1", {7'd0, req1_ready}, 8'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'd2; req0_b = 4'd9;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
            chk("bp_data", {4'd0, rsp_data}, 8'd7);
            chk("bp_id", {7'd0, rsp_id}, 8'd1);
            chk("bp_ready0", {7'd0, req0_ready}, 8'd0);
            chk("bp_ready1", {7'd0, req1_ready}, 8'd0);
            chk("bp_count", {6'd0, op_count}, 8'd3);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle", {7'd0, busy}, 8'd0);
        chk("bp_wrap", {6'd0, op_count}, 8'd0);
        chk("bp_next_grant", {7'd0, req0_ready}, 8'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk("next_data", {4'd0, rsp_data}, 8'd11);
        chk("next_id", {7'd0, rsp_id}, 8'd0);
        step();
        chk("count_wrap_1", {6'd0, op_count}, 8'd1);

        // abort in EXEC; rr was left at 1 by the last req0 grant
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'd7; req0_b = 4'd7;
        step();
        req0_valid = 1'b0;
        #1;
        chk("abort_exec", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_count", {6'd0, op_count}, 8'd0);
        chk("abort_alu_a", {4'd0, alu_a}, 8'd0);
        step();
        rst = 1'b0;
        step();
        chk("abort_no_rsp", {7'd0, rsp_valid}, 8'd0);
        step();
        chk("abort_no_rsp2", {7'd0, rsp_valid}, 8'd0);

        // contention: both valid, grants alternate starting with requester 0
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 4'd5; req0_b = 4'd3;
        req1_valid = 1'b1; req1_op = 2'd2; req1_a = 4'd5; req1_b = 4'd3;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready0", {7'd0, req0_ready}, (i % 2 == 0) ? 8'd1 : 8'd0);
            chk("rr_ready1", {7'd0, req1_ready}, (i % 2 == 1) ? 8'd1 : 8'd0);
            step();
            step();
            chk("rr_data", {4'd0, rsp_data}, (i % 2 == 0) ? 8'd2 : 8'd1);
            chk("rr_id", {7'd0, rsp_id}, (i % 2 == 1) ? 8'd1 : 8'd0);
            step();
            chk("rr_count", {6'd0, op_count}, 8'((i + 1) % 4));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
